// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the ALU (requester 0)
//   and the load/store unit (requester 1) using round-robin arbitration with a
//   valid/ready handshake. The write port outputs are registered, so they are
//   stable before the register file's negedge write. A per-register busy
//   scoreboard lets the issue stage detect pending writes (RAW hazards).
//
// Ports
//   clk, rst_n                      clock (posedge), async active-low reset
//   req0_valid/addr/data, req0_ready  ALU writeback handshake
//   req1_valid/addr/data, req1_ready  LSU writeback handshake
//   issue_valid, issue_addr         destination of a newly issued instruction
//   chk_addr_1/2, chk_busy_1/2      source-register pending-write lookup
//   rf_we, rf_w_addr, rf_in         registered register file write port
module regfile_wb_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGNO = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    input  logic [AW-1:0]    chk_addr_1,
    input  logic [AW-1:0]    chk_addr_2,
    output logic             chk_busy_1,
    output logic             chk_busy_2,
    output logic             rf_we,
    output logic [AW-1:0]    rf_w_addr,
    output logic [WIDTH-1:0] rf_in
);

    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_grant_e;

    last_grant_e      last_grant_q, last_grant_d;
    logic             we_q, we_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [REGNO-1:0] busy_q, busy_d;
    logic             gnt0, gnt1;

    // Grants are gated by rst_n so ready reads 0 while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q == LAST_REQ1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        busy_d       = busy_q;

        if (gnt0) begin
            last_grant_d = LAST_REQ0;
            we_d         = (req0_addr != '0);
            waddr_d      = req0_addr;
            wdata_d      = req0_data;
            busy_d[req0_addr] = 1'b0;
        end else if (gnt1) begin
            last_grant_d = LAST_REQ1;
            we_d         = (req1_addr != '0);
            waddr_d      = req1_addr;
            wdata_d      = req1_data;
            busy_d[req1_addr] = 1'b0;
        end

        // Set is applied after clear: a newer producer stays outstanding.
        if (issue_valid && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LAST_REQ1;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_w_addr  = waddr_q;
    assign rf_in      = wdata_q;
    assign chk_busy_1 = rst_n & busy_q[chk_addr_1];
    assign chk_busy_2 = rst_n & busy_q[chk_addr_2];

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load/store unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file write port from registered outputs, so they are stable before the register file's negedge write.
- Keeps a per-register busy scoreboard so the issue stage can detect pending writes (RAW hazard check).

Parameters:
WIDTH, 32, data width of register file entries
REGNO, 32, number of architectural registers
AW, 5, register address width, equal to log2(REGNO)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  ALU writeback request
req0_addr  input  AW  ALU destination register
req0_data  input  WIDTH  ALU result
req0_ready  output  1  ALU request accepted this cycle
req1_valid  input  1  LSU writeback request
req1_addr  input  AW  LSU destination register
req1_data  input  WIDTH  LSU load data
req1_ready  output  1  LSU request accepted this cycle
issue_valid  input  1  instruction issued with a destination register
issue_addr  input  AW  destination register of the issued instruction
chk_addr_1  input  AW  source register 1 to check
chk_addr_2  input  AW  source register 2 to check
chk_busy_1  output  1  chk_addr_1 has a pending write
chk_busy_2  output  1  chk_addr_2 has a pending write
rf_we  output  1  register file write enable (registered)
rf_w_addr  output  AW  register file write address (registered)
rf_in  output  WIDTH  register file write data (registered)

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_w_addr=0, rf_in=0.
  - All busy bits cleared.
  - Round-robin pointer last_grant=1, so requester 0 has priority on the first contention.
  - req*_ready and chk_busy_* read 0 while in reset.
- Arbitration (combinational within cycle N):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
  - reqX_ready=1 only for the granted requester. At most one ready per cycle.
  - Ready is never asserted without the matching valid.
- Handshake:
  - A transfer occurs when valid && ready at the posedge ending cycle N.
  - A requester that is not granted must hold valid, addr and data stable until granted.
  - The block accepts one transfer per cycle, with no backpressure from the register file.
- Write port (latency 1):
  - At the posedge ending cycle N, rf_we, rf_w_addr and rf_in load the granted request's values.
  - rf_we is high for exactly one cycle (N+1) per transfer.
  - With no grant, rf_we=0 in N+1. rf_w_addr and rf_in hold their previous values.
  - The register file writes on the negedge within N+1.
  - Back-to-back grants give rf_we high on consecutive cycles.
- Round-robin pointer: last_grant updates to the granted index on every transfer and is unchanged otherwise.
- Address 0:
  - A request to register 0 is granted and handshaken normally.
  - rf_we stays 0 for that transfer, so x0 is never written.
  - last_grant still updates.
- Scoreboard:
  - One busy bit per register. busy[0] is constant 0.
  - Set: issue_valid && issue_addr!=0 sets busy[issue_addr] at posedge.
  - Clear: a transfer to addr A clears busy[A] at the same posedge that loads rf_we.
  - Set and clear on the same register in the same cycle: set wins (a newer producer is outstanding).
  - Set on an already-busy register leaves it busy. There is no counting; one outstanding producer per register.
  - chk_busy_k = busy[chk_addr_k], combinational from the current busy bits. There is no bypass of same-cycle issue or clear.
- Reset mid-operation: in-flight rf_we drops immediately, pending busy bits are lost, and requesters must re-present after reset.

Test Plan:
- Reset release, no requests → rf_we=0 every cycle; chk_busy_1 and chk_busy_2 are 0 for all addresses.
- req0 alone, addr=5, data=0xDEADBEEF → req0_ready=1 in cycle N; cycle N+1 shows rf_we=1, rf_w_addr=5, rf_in=0xDEADBEEF; cycle N+2 shows rf_we=0.
- Both requesters held valid (req0 addr=3 data=0x11, req1 addr=4 data=0x22) for 4 cycles after reset → grant order 0,1,0,1; rf_w_addr sequence 3,4,3,4 with rf_we high on 4 consecutive cycles.
- issue_valid addr=7, then a later req1 transfer to addr 7 → chk_busy (chk_addr_1=7) is 1 from the cycle after issue until the transfer posedge, and 0 afterward.
- Same cycle: issue_valid addr=9 and a req0 transfer to addr 9 (busy[9] previously 1) → busy[9] remains 1; rf_we=1 with rf_w_addr=9 next cycle.
- req0 addr=0 data=0xFFFFFFFF → req0_ready=1, rf_we stays 0; issue_valid addr=0 → chk_busy for address 0 stays 0. Then assert rst_n=0 mid-transfer → rf_we drops asynchronously.
